// File: rtl/dog_builder.sv
// Streams three Gaussian scales in raster order and writes the two signed DoG images (g1-g0, g2-g1).
// Optional DOG_STATS_EN macro enables per-pass peak |DoG| tracking on first_max_abs/second_max_abs.
module dog_builder #(
   parameter int BIT_DEPTH    = 8,
   parameter int DIMENSION    = 4,
   parameter int BRAM_LATENCY = 2,
   localparam int AW          = $clog2(DIMENSION*DIMENSION)
) (
   input  logic                 clk,
   input  logic                 rst_in,
   input  logic                 start,
   output logic [AW-1:0]        gauss_address,
   input  logic [BIT_DEPTH-1:0] g0_data,
   input  logic [BIT_DEPTH-1:0] g1_data,
   input  logic [BIT_DEPTH-1:0] g2_data,
   output logic [AW-1:0]        dog_address,
   output logic                 dog_we,
   output logic [BIT_DEPTH:0]   first_dog_data,
   output logic [BIT_DEPTH:0]   second_dog_data,
   output logic                 busy,
   output logic                 done,
   output logic [BIT_DEPTH-1:0] first_max_abs,
   output logic [BIT_DEPTH-1:0] second_max_abs
);

   localparam logic [AW-1:0] LAST = AW'(DIMENSION*DIMENSION-1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                 state_q;
   logic [AW-1:0]          gauss_addr_q;
   logic                   busy_q;
   logic                   done_q;

   logic [BRAM_LATENCY-1:0]         vld_pipe_q;
   logic [BRAM_LATENCY-1:0][AW-1:0] tag_pipe_q;

   logic [AW-1:0]          dog_addr_q;
   logic                   dog_we_q;
   logic [BIT_DEPTH:0]     first_q;
   logic [BIT_DEPTH:0]     second_q;

   logic                   accept;
   logic                   issue;
   logic                   last_write;
   logic [BIT_DEPTH:0]     first_d;
   logic [BIT_DEPTH:0]     second_d;

   assign accept     = (state_q == IDLE) && start;
   assign issue      = (state_q == RUN);
   assign last_write = dog_we_q && (dog_addr_q == LAST);

   // Zero-extend both operands so the 9-bit signed result never wraps.
   assign first_d  = {1'b0, g1_data} - {1'b0, g0_data};
   assign second_d = {1'b0, g2_data} - {1'b0, g1_data};

   always_ff @(posedge clk) begin
      if (!rst_in) begin
         state_q      <= IDLE;
         gauss_addr_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q      <= RUN;
                  gauss_addr_q <= '0;
                  busy_q       <= 1'b1;
               end
            end
            RUN: begin
               if (gauss_addr_q == LAST) state_q <= DRAIN;
               else gauss_addr_q <= gauss_addr_q + AW'(1);
            end
            DRAIN: begin
               if (last_write) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Each read carries its address through a shift register matching the BRAM latency.
   always_ff @(posedge clk) begin
      if (!rst_in) begin
         vld_pipe_q <= '0;
         tag_pipe_q <= '0;
         dog_we_q   <= 1'b0;
         dog_addr_q <= '0;
         first_q    <= '0;
         second_q   <= '0;
      end else begin
         vld_pipe_q[0] <= issue;
         tag_pipe_q[0] <= gauss_addr_q;
         for (int i = 1; i < BRAM_LATENCY; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            tag_pipe_q[i] <= tag_pipe_q[i-1];
         end
         dog_we_q <= vld_pipe_q[BRAM_LATENCY-1];
         if (vld_pipe_q[BRAM_LATENCY-1]) begin
            dog_addr_q <= tag_pipe_q[BRAM_LATENCY-1];
            first_q    <= first_d;
            second_q   <= second_d;
         end
      end
   end

`ifdef DOG_STATS_EN
   logic [BIT_DEPTH-1:0] first_max_q;
   logic [BIT_DEPTH-1:0] second_max_q;
   logic [BIT_DEPTH-1:0] first_abs;
   logic [BIT_DEPTH-1:0] second_abs;
   logic [BIT_DEPTH:0]   first_neg;
   logic [BIT_DEPTH:0]   second_neg;

   // |x| of a BIT_DEPTH+1 signed value never exceeds 2^BIT_DEPTH-1, so BIT_DEPTH bits suffice.
   assign first_neg  = ~first_q + (BIT_DEPTH+1)'(1);
   assign second_neg = ~second_q + (BIT_DEPTH+1)'(1);
   assign first_abs  = first_q[BIT_DEPTH]  ? first_neg[BIT_DEPTH-1:0]  : first_q[BIT_DEPTH-1:0];
   assign second_abs = second_q[BIT_DEPTH] ? second_neg[BIT_DEPTH-1:0] : second_q[BIT_DEPTH-1:0];

   always_ff @(posedge clk) begin
      if (!rst_in) begin
         first_max_q  <= '0;
         second_max_q <= '0;
      end else if (accept) begin
         first_max_q  <= '0;
         second_max_q <= '0;
      end else if (dog_we_q) begin
         if (first_abs > first_max_q)   first_max_q  <= first_abs;
         if (second_abs > second_max_q) second_max_q <= second_abs;
      end
   end

   assign first_max_abs  = first_max_q;
   assign second_max_abs = second_max_q;
`else
   assign first_max_abs  = '0;
   assign second_max_abs = '0;
`endif

   assign gauss_address   = gauss_addr_q;
   assign dog_address     = dog_addr_q;
   assign dog_we          = dog_we_q;
   assign first_dog_data  = first_q;
   assign second_dog_data = second_q;
   assign busy            = busy_q;
   assign done            = done_q;

endmodule

// File: tb/tb_dog_builder.sv
// Directed bench for dog_builder: BRAM model with 2-cycle latency, hand-computed DoG values per pattern.
module tb_dog_builder;

   logic       clk = 1'b0;
   logic       rst_in;
   logic       start;
   logic [3:0] gauss_address;
   logic [7:0] g0_data, g1_data, g2_data;
   logic [3:0] dog_address;
   logic       dog_we;
   logic [8:0] first_dog_data, second_dog_data;
   logic       busy, done;
   logic [7:0] first_max_abs, second_max_abs;

   int n_chk  = 0;
   int n_fail = 0;
   int pat    = 0;

   dog_builder #(.BIT_DEPTH(8), .DIMENSION(4), .BRAM_LATENCY(2)) dut (
      .clk(clk), .rst_in(rst_in), .start(start),
      .gauss_address(gauss_address),
      .g0_data(g0_data), .g1_data(g1_data), .g2_data(g2_data),
      .dog_address(dog_address), .dog_we(dog_we),
      .first_dog_data(first_dog_data), .second_dog_data(second_dog_data),
      .busy(busy), .done(done),
      .first_max_abs(first_max_abs), .second_max_abs(second_max_abs)
   );

   always #5 clk = ~clk;

   // Gaussian BRAM model: data valid two cycles after the address.
   logic [3:0] a1 = '0, a2 = '0;
   always @(posedge clk) begin
      a1 <= gauss_address;
      a2 <= a1;
   end

   always_comb begin
      g0_data = 8'd0; g1_data = 8'd0; g2_data = 8'd0;
      case (pat)
         0: begin g0_data = 8'd10;  g1_data = 8'd30; g2_data = 8'd25;  end
         1: begin g0_data = 8'd255; g1_data = 8'd0;  g2_data = 8'd255; end
         default: begin g0_data = {4'b0, a2}; g1_data = {3'b0, a2, 1'b0}; g2_data = 8'd0; end
      endcase
   end

   function automatic logic [8:0] exp_first(input int p, input int a);
      case (p)
         0: return 9'h014;
         1: return 9'h101;
         default: return 9'(a);
      endcase
   endfunction

   function automatic logic [8:0] exp_second(input int p, input int a);
      case (p)
         0: return 9'h1FB;
         1: return 9'h0FF;
         default: return 9'(-2 * a);
      endcase
   endfunction

   function automatic logic [7:0] exp_max1(input int p);
`ifdef DOG_STATS_EN
      case (p)
         0: return 8'd20;
         1: return 8'd255;
         default: return 8'd15;
      endcase
`else
      return 8'd0;
`endif
   endfunction

   function automatic logic [7:0] exp_max2(input int p);
`ifdef DOG_STATS_EN
      case (p)
         0: return 8'd5;
         1: return 8'd255;
         default: return 8'd30;
      endcase
`else
      return 8'd0;
`endif
   endfunction

   task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input int c);
      chk("rst_gaddr", c, 32'(gauss_address), 32'd0);
      chk("rst_daddr", c, 32'(dog_address), 32'd0);
      chk("rst_we",    c, 32'(dog_we), 32'd0);
      chk("rst_first", c, 32'(first_dog_data), 32'd0);
      chk("rst_second",c, 32'(second_dog_data), 32'd0);
      chk("rst_busy",  c, 32'(busy), 32'd0);
      chk("rst_done",  c, 32'(done), 32'd0);
      chk("rst_max1",  c, 32'(first_max_abs), 32'd0);
      chk("rst_max2",  c, 32'(second_max_abs), 32'd0);
   endtask

   // Full pass: start sampled at end of cycle 0, checks at every negedge through cycle 20 (done).
   task automatic run_pass(input int p, input bit repulse);
      pat = p;
      @(negedge clk);
      chk("idle_busy", 0, 32'(busy), 32'd0);
      chk("idle_we",   0, 32'(dog_we), 32'd0);
      start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = repulse && (c == 5 || c == 20);
         if (c <= 16) chk("gaddr", c, 32'(gauss_address), 32'(c - 1));
         else if (c <= 19) chk("gaddr_hold", c, 32'(gauss_address), 32'd15);
         chk("we", c, 32'(dog_we), 32'(c >= 4 && c <= 19));
         if (c >= 4 && c <= 19) begin
            chk("daddr",  c, 32'(dog_address), 32'(c - 4));
            chk("first",  c, 32'(first_dog_data), 32'(exp_first(p, c - 4)));
            chk("second", c, 32'(second_dog_data), 32'(exp_second(p, c - 4)));
         end
         chk("done", c, 32'(done), 32'(c == 20));
         chk("busy", c, 32'(busy), 32'(c <= 19));
         if (c == 20) begin
            chk("max1", c, 32'(first_max_abs), 32'(exp_max1(p)));
            chk("max2", c, 32'(second_max_abs), 32'(exp_max2(p)));
         end
      end
      start = 1'b0;
   endtask

   initial begin
      rst_in = 1'b0;
      start  = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero(0);
      rst_in = 1'b1;

      run_pass(0, 1'b0);
      run_pass(1, 1'b0);
      run_pass(2, 1'b0);
      // Re-pulses in busy and done cycles are ignored; the next call starts on the cycle after done.
      run_pass(0, 1'b1);
      run_pass(2, 1'b0);

      // Mid-pass reset: start sampled end of cycle 0, reset sampled end of cycle 9.
      pat = 0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 9) rst_in = 1'b0;
         if (c == 10) rst_in = 1'b1;
         if (c >= 10) begin
            chk("post_rst_we",   c, 32'(dog_we), 32'd0);
            chk("post_rst_busy", c, 32'(busy), 32'd0);
            chk("post_rst_done", c, 32'(done), 32'd0);
         end
         if (c == 10) chk_all_zero(c);
      end
      run_pass(0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
